io_port_bridge: RTL and testbench
=================================

IO_PORT_BRIDGE -- requirements
Module: io_port_bridge

Interface
REQ-001 Parameter: WIDTH, 16, data word width shared with the processor's input_IO/output_IO.
REQ-002 Parameter: DEPTH, 4, entries per FIFO; power of two, 2..16.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: host_in_data  input  WIDTH  word from host, destined for processor input_IO.
REQ-006 Port: host_in_valid  input  1  host_in_data valid.
REQ-007 Port: host_in_ready  output  1  bridge accepts host_in_data this cycle.
REQ-008 Port: input_IO  output  WIDTH  head of input FIFO, driven to processor.
REQ-009 Port: cpu_in_re  input  1  processor consumed input_IO this cycle (pop).
REQ-010 Port: output_IO  input  WIDTH  word from processor output register.
REQ-011 Port: cpu_out_we  input  1  processor wrote output_IO this cycle (push).
REQ-012 Port: host_out_data  output  WIDTH  head of output FIFO, to host.
REQ-013 Port: host_out_valid  output  1  host_out_data valid.
REQ-014 Port: host_out_ready  input  1  host consumes host_out_data this cycle.
REQ-015 Port: in_count, out_count  output  log2(DEPTH)+1  current occupancy of each FIFO.
REQ-016 Port: in_underflow, out_overflow  output  1  sticky error flags.
REQ-017 Port: clr_err  input  1  synchronous clear of both sticky flags.

Function
REQ-018 Input FIFO SHALL push host_in_data on an edge where host_in_valid && host_in_ready; host_in_ready = (in_count != DEPTH), combinational from occupancy only.
REQ-019 input_IO SHALL equal the head entry when in_count > 0, and all-zeros when empty; no combinational path from cpu_in_re.
REQ-020 cpu_in_re with in_count > 0 SHALL pop one entry at that edge; new head visible the following cycle.
REQ-021 cpu_in_re with in_count = 0 SHALL set in_underflow, leave pointers unchanged; a same-cycle host push SHALL still be stored (not consumed).
REQ-022 Simultaneous push and pop on a non-empty, non-full input FIFO SHALL leave in_count unchanged; when full, pop proceeds and push is refused (ready low).
REQ-023 Write-to-read latency: word accepted at edge N SHALL appear on input_IO after edge N (one cycle).
REQ-024 Output FIFO SHALL push output_IO on edge where cpu_out_we && out_count != DEPTH.
REQ-025 cpu_out_we with out_count = DEPTH SHALL set out_overflow and drop the word; a same-cycle host pop SHALL still occur.
REQ-026 host_out_valid = (out_count != 0); host_out_data = head entry, all-zeros when empty; pop on host_out_valid && host_out_ready.
REQ-027 Simultaneous push and pop on non-empty output FIFO SHALL keep out_count unchanged and preserve order.
REQ-028 Pointers SHALL wrap modulo DEPTH; occupancy counters SHALL never exceed DEPTH nor go below 0.
REQ-029 Sticky flags SHALL hold until clr_err or reset; clr_err coincident with a new error event SHALL leave the flag set (set wins).
REQ-030 Both FIFOs SHALL preserve strict FIFO order; no data path between the two FIFOs.

Reset
REQ-031 While reset = 0, all pointers, counters and flags SHALL be 0 immediately (asynchronous), independent of clk.
REQ-032 During reset: host_in_ready = 0, host_out_valid = 0, input_IO = 0, host_out_data = 0; storage contents need not be cleared.
REQ-033 After reset deasserts, host_in_ready SHALL be 1 in the first cycle; reset asserted mid-transfer SHALL discard all queued words.

Verification
REQ-034 Reset 0 then 1; host pushes 5040 -> next cycle input_IO = 5040, in_count = 1; cpu_in_re pulse -> input_IO = 0, in_count = 0.
REQ-035 Host pushes 1,2,3,4,5 back-to-back (DEPTH 4) -> host_in_ready drops after 4th; 5 held by host until one cpu_in_re; processor reads 1,2,3,4,5 in order.
REQ-036 cpu_in_re on empty FIFO -> in_underflow = 1, in_count = 0; clr_err pulse -> in_underflow = 0.
REQ-037 cpu_out_we with output_IO = 8,17,25,43,99, host_out_ready = 0 -> out_count = 4, out_overflow = 1, host drains 8,17,25,43.
REQ-038 Output FIFO full, cpu_out_we and host_out_ready same cycle -> word dropped, out_overflow = 1, out_count = 3.
REQ-039 reset driven low between clock edges with 3 words queued -> counts 0 and valids low before next edge.

Source files
------------

// File: rtl/io_port_bridge.sv
// io_port_bridge: pair of small FIFOs between a host link and the
// processor input_IO / output_IO registers, with sticky error flags.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   host_in_*            host -> input FIFO (valid/ready push side)
//   input_IO, cpu_in_re  input FIFO head to processor; pop strobe
//   output_IO,cpu_out_we processor word and push strobe -> output FIFO
//   host_out_*           output FIFO -> host (valid/ready pop side)
//   in_count,out_count   FIFO occupancy
//   in_underflow         sticky: pop attempted on empty input FIFO
//   out_overflow         sticky: push attempted on full output FIFO
//   clr_err              synchronous clear of both sticky flags
module io_port_bridge #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       host_in_data,
  input  logic                   host_in_valid,
  output logic                   host_in_ready,
  output logic [WIDTH-1:0]       input_IO,
  input  logic                   cpu_in_re,
  input  logic [WIDTH-1:0]       output_IO,
  input  logic                   cpu_out_we,
  output logic [WIDTH-1:0]       host_out_data,
  output logic                   host_out_valid,
  input  logic                   host_out_ready,
  output logic [$clog2(DEPTH):0] in_count,
  output logic [$clog2(DEPTH):0] out_count,
  output logic                   in_underflow,
  output logic                   out_overflow,
  input  logic                   clr_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [CW-1:0] CONE = CW'(1);

  // storage (not reset; occupancy alone defines validity)
  logic [WIDTH-1:0] in_mem_q  [DEPTH];
  logic [WIDTH-1:0] out_mem_q [DEPTH];

  logic [PW-1:0] in_wr_ptr_q,  in_wr_ptr_d;
  logic [PW-1:0] in_rd_ptr_q,  in_rd_ptr_d;
  logic [CW-1:0] in_count_q,   in_count_d;
  logic [PW-1:0] out_wr_ptr_q, out_wr_ptr_d;
  logic [PW-1:0] out_rd_ptr_q, out_rd_ptr_d;
  logic [CW-1:0] out_count_q,  out_count_d;
  logic          in_underflow_q, in_underflow_d;
  logic          out_overflow_q, out_overflow_d;

  logic in_full, in_empty, in_push, in_pop, in_err;
  logic out_full, out_empty, out_push, out_pop, out_err;

  // ---------------- input FIFO ----------------
  always_comb begin
    in_full  = (in_count_q == FULL);
    in_empty = (in_count_q == '0);
    // ready also drops while reset is held
    host_in_ready = reset & ~in_full;
    in_push  = host_in_valid & host_in_ready;
    in_pop   = cpu_in_re & ~in_empty;
    in_err   = cpu_in_re & in_empty;
  end

  always_comb begin
    in_wr_ptr_d = in_wr_ptr_q;
    in_rd_ptr_d = in_rd_ptr_q;
    in_count_d  = in_count_q;
    if (in_push) in_wr_ptr_d = in_wr_ptr_q + PONE;
    if (in_pop)  in_rd_ptr_d = in_rd_ptr_q + PONE;
    unique case ({in_push, in_pop})
      2'b10:   in_count_d = in_count_q + CONE;
      2'b01:   in_count_d = in_count_q - CONE;
      default: in_count_d = in_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_push) in_mem_q[in_wr_ptr_q] <= host_in_data;
  end

  assign input_IO = in_empty ? '0 : in_mem_q[in_rd_ptr_q];

  // ---------------- output FIFO ----------------
  always_comb begin
    out_full  = (out_count_q == FULL);
    out_empty = (out_count_q == '0);
    out_push  = cpu_out_we & ~out_full;
    out_err   = cpu_out_we & out_full;
    out_pop   = ~out_empty & host_out_ready;
  end

  always_comb begin
    out_wr_ptr_d = out_wr_ptr_q;
    out_rd_ptr_d = out_rd_ptr_q;
    out_count_d  = out_count_q;
    if (out_push) out_wr_ptr_d = out_wr_ptr_q + PONE;
    if (out_pop)  out_rd_ptr_d = out_rd_ptr_q + PONE;
    unique case ({out_push, out_pop})
      2'b10:   out_count_d = out_count_q + CONE;
      2'b01:   out_count_d = out_count_q - CONE;
      default: out_count_d = out_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (out_push) out_mem_q[out_wr_ptr_q] <= output_IO;
  end

  assign host_out_valid = ~out_empty;
  assign host_out_data  = out_empty ? '0 : out_mem_q[out_rd_ptr_q];

  // ---------------- sticky flags ----------------
  // a new error event beats a coincident clear
  always_comb begin
    in_underflow_d = in_underflow_q;
    out_overflow_d = out_overflow_q;
    if (clr_err) begin
      in_underflow_d = 1'b0;
      out_overflow_d = 1'b0;
    end
    if (in_err)  in_underflow_d = 1'b1;
    if (out_err) out_overflow_d = 1'b1;
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr_ptr_q    <= '0;
      in_rd_ptr_q    <= '0;
      in_count_q     <= '0;
      out_wr_ptr_q   <= '0;
      out_rd_ptr_q   <= '0;
      out_count_q    <= '0;
      in_underflow_q <= 1'b0;
      out_overflow_q <= 1'b0;
    end else begin
      in_wr_ptr_q    <= in_wr_ptr_d;
      in_rd_ptr_q    <= in_rd_ptr_d;
      in_count_q     <= in_count_d;
      out_wr_ptr_q   <= out_wr_ptr_d;
      out_rd_ptr_q   <= out_rd_ptr_d;
      out_count_q    <= out_count_d;
      in_underflow_q <= in_underflow_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  assign in_count     = in_count_q;
  assign out_count    = out_count_q;
  assign in_underflow = in_underflow_q;
  assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_io_port_bridge.sv
// tb_io_port_bridge: directed checks of io_port_bridge
// (WIDTH 16, DEPTH 4).
module tb_io_port_bridge;

  logic        clk;
  logic        reset;
  logic [15:0] host_in_data;
  logic        host_in_valid;
  logic        host_in_ready;
  logic [15:0] input_IO;
  logic        cpu_in_re;
  logic [15:0] output_IO;
  logic        cpu_out_we;
  logic [15:0] host_out_data;
  logic        host_out_valid;
  logic        host_out_ready;
  logic [2:0]  in_count;
  logic [2:0]  out_count;
  logic        in_underflow;
  logic        out_overflow;
  logic        clr_err;

  int vectors = 0;
  int miscompares = 0;

  io_port_bridge #(.WIDTH(16), .DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_in_data  (host_in_data),
    .host_in_valid (host_in_valid),
    .host_in_ready (host_in_ready),
    .input_IO      (input_IO),
    .cpu_in_re     (cpu_in_re),
    .output_IO     (output_IO),
    .cpu_out_we    (cpu_out_we),
    .host_out_data (host_out_data),
    .host_out_valid(host_out_valid),
    .host_out_ready(host_out_ready),
    .in_count      (in_count),
    .out_count     (out_count),
    .in_underflow  (in_underflow),
    .out_overflow  (out_overflow),
    .clr_err       (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] in_exp [4];
    logic [15:0] ow [5];
    in_exp = '{16'd2, 16'd3, 16'd4, 16'd5};
    ow     = '{16'd8, 16'd17, 16'd25, 16'd43, 16'd99};

    reset = 1'b0;
    host_in_data = '0;
    host_in_valid = 1'b0;
    cpu_in_re = 1'b0;
    output_IO = '0;
    cpu_out_we = 1'b0;
    host_out_ready = 1'b0;
    clr_err = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_in_ready", host_in_ready, 0);
    chk("rst_out_valid", host_out_valid, 0);
    chk("rst_input_IO", input_IO, 0);
    chk("rst_out_data", host_out_data, 0);
    chk("rst_in_count", in_count, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_underflow", in_underflow, 0);
    chk("rst_overflow", out_overflow, 0);
    reset = 1'b1;
    #1;
    chk("post_rst_ready", host_in_ready, 1);

    // single word 5040
    host_in_data = 16'd5040;
    host_in_valid = 1'b1;
    tick();
    host_in_valid = 1'b0;
    chk("w5040_io", input_IO, 5040);
    chk("w5040_cnt", in_count, 1);
    cpu_in_re = 1'b1;
    tick();
    cpu_in_re = 1'b0;
    chk("w5040_pop_io", input_IO, 0);
    chk("w5040_pop_cnt", in_count, 0);

    // 1..5 back to back into depth 4
    host_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      host_in_data = 16'(i);
      tick();
    end
    chk("fill_cnt", in_count, 4);
    chk("fill_ready", host_in_ready, 0);
    host_in_data = 16'd5;
    tick();
    chk("full_hold_cnt", in_count, 4);
    chk("full_head", input_IO, 1);
    cpu_in_re = 1'b1;
    tick();
    chk("full_pop_cnt", in_count, 3);
    chk("full_pop_ready", host_in_ready, 1);
    cpu_in_re = 1'b0;
    tick();
    host_in_valid = 1'b0;
    chk("push5_cnt", in_count, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd_order%0d", i), input_IO, in_exp[i]);
      cpu_in_re = 1'b1;
      tick();
    end
    cpu_in_re = 1'b0;
    chk("drain_cnt", in_count, 0);
    chk("drain_io", input_IO, 0);

    // underflow and clear
    cpu_in_re = 1'b1;
    tick();
    cpu_in_re = 1'b0;
    chk("uf_flag", in_underflow, 1);
    chk("uf_cnt", in_count, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("uf_clr", in_underflow, 0);
    // pop on empty with same-cycle push: word kept
    cpu_in_re = 1'b1;
    host_in_valid = 1'b1;
    host_in_data = 16'h0077;
    tick();
    cpu_in_re = 1'b0;
    host_in_valid = 1'b0;
    chk("uf_push_flag", in_underflow, 1);
    chk("uf_push_cnt", in_count, 1);
    chk("uf_push_io", input_IO, 16'h0077);
    cpu_in_re = 1'b1;
    tick();
    chk("uf_pop_cnt", in_count, 0);
    // clear together with new error: flag stays set
    clr_err = 1'b1;
    tick();
    cpu_in_re = 1'b0;
    chk("set_wins", in_underflow, 1);
    tick();
    clr_err = 1'b0;
    chk("clr_after", in_underflow, 0);

    // output FIFO fill with overflow
    cpu_out_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      output_IO = ow[i];
      tick();
    end
    cpu_out_we = 1'b0;
    chk("of_cnt", out_count, 4);
    chk("of_flag", out_overflow, 1);
    chk("of_valid", host_out_valid, 1);
    host_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_order%0d", i), host_out_data, ow[i]);
      tick();
    end
    host_out_ready = 1'b0;
    chk("out_empty_valid", host_out_valid, 0);
    chk("out_empty_data", host_out_data, 0);
    chk("out_empty_cnt", out_count, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("of_clr", out_overflow, 0);

    // full + push + pop same cycle: word dropped, pop occurs
    cpu_out_we = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      output_IO = 16'(i * 16'h0101);
      tick();
    end
    output_IO = 16'hdead;
    host_out_ready = 1'b1;
    tick();
    chk("fpp_cnt", out_count, 3);
    chk("fpp_flag", out_overflow, 1);
    chk("fpp_head", host_out_data, 16'h0202);
    // non-full simultaneous push/pop keeps count and order
    output_IO = 16'h0055;
    tick();
    cpu_out_we = 1'b0;
    chk("spp_cnt", out_count, 3);
    chk("spp_head", host_out_data, 16'h0303);
    tick();
    chk("spp_next", host_out_data, 16'h0404);
    tick();
    chk("spp_last", host_out_data, 16'h0055);
    tick();
    host_out_ready = 1'b0;
    chk("spp_empty", out_count, 0);

    // asynchronous reset mid-transfer
    host_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_in_data = 16'(16'h0100 + i);
      tick();
    end
    host_in_valid = 1'b0;
    cpu_out_we = 1'b1;
    output_IO = 16'h0aaa;
    tick();
    cpu_out_we = 1'b0;
    chk("pre_ar_in", in_count, 3);
    chk("pre_ar_out", out_count, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_in_cnt", in_count, 0);
    chk("ar_out_cnt", out_count, 0);
    chk("ar_ready", host_in_ready, 0);
    chk("ar_valid", host_out_valid, 0);
    chk("ar_io", input_IO, 0);
    chk("ar_flag", out_overflow, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("ar_rel_ready", host_in_ready, 1);
    tick();
    chk("ar_rel_cnt", in_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
